// File: rtl/dvp_bayer_tx.sv
// DVP raw-Bayer (BGGR) test-pattern transmitter.
// Generates vsync / HREF framing and one of four 8-bit test patterns,
// one pixel per clock, with every output registered.
module dvp_bayer_tx #(
  parameter int VIDEO_WIDTH      = 1280,
  parameter int VIDEO_HEIGHT     = 720,
  parameter int VIDEO_DATA_WIDTH = 8,
  parameter int H_BLANK          = 64,
  parameter int VSYNC_LINES      = 4,
  parameter int V_BACK           = 16,
  parameter int V_FRONT          = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [1:0]                  pattern_sel,
  output logic [VIDEO_DATA_WIDTH-1:0] out_data,
  output logic                        out_vsync,
  output logic                        out_hsync,
  output logic                        out_frame_done
);

  localparam int LP    = VIDEO_WIDTH + H_BLANK;
  localparam int XW    = $clog2(LP);
  localparam int YW    = 16;
  localparam int BAR_W = VIDEO_WIDTH / 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VSYNC  = 3'd1;
  localparam logic [2:0] S_VBACK  = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_VFRONT = 3'd4;

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [7:0]    f;
  logic [1:0]    pat;
  logic [YW-1:0] state_lines;
  logic          line_end;
  logic          last_line;
  logic          frame_end;
  logic          href_p0;
  logic [2:0]    bar_p0;
  logic [7:0]    pix_p0;

  // Colour bar RGB presence, bars ordered white..black: {R, G, B}
  function automatic logic [2:0] bar_rgb(input logic [2:0] b);
    case (b)
      3'd0:    bar_rgb = 3'b111;
      3'd1:    bar_rgb = 3'b110;
      3'd2:    bar_rgb = 3'b011;
      3'd3:    bar_rgb = 3'b010;
      3'd4:    bar_rgb = 3'b101;
      3'd5:    bar_rgb = 3'b100;
      3'd6:    bar_rgb = 3'b001;
      default: bar_rgb = 3'b000;
    endcase
  endfunction

  assign line_end  = (x == XW'(LP - 1));
  assign last_line = (y == state_lines - YW'(1));
  assign frame_end = (state == S_VFRONT) && line_end && last_line;
  assign href_p0   = (state == S_ACTIVE) && (x < XW'(VIDEO_WIDTH));
  assign bar_p0    = 3'(x / XW'(BAR_W));

  // Number of line periods spent in the current state
  always_comb begin
    state_lines = YW'(1);
    case (state)
      S_VSYNC:  state_lines = YW'(VSYNC_LINES);
      S_VBACK:  state_lines = YW'(V_BACK);
      S_ACTIVE: state_lines = YW'(VIDEO_HEIGHT);
      S_VFRONT: state_lines = YW'(V_FRONT);
      default:  state_lines = YW'(1);
    endcase
  end

  // Frame sequencing; vertical states advance only at the end of their last line
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (enable) state_nxt = S_VSYNC;
      S_VSYNC:  if (line_end && last_line) state_nxt = S_VBACK;
      S_VBACK:  if (line_end && last_line) state_nxt = S_ACTIVE;
      S_ACTIVE: if (line_end && last_line) state_nxt = S_VFRONT;
      S_VFRONT: if (line_end && last_line) state_nxt = enable ? S_VSYNC : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Pattern pixel for the current (x, y); y is the active row inside ACTIVE
  always_comb begin
    pix_p0 = 8'h00;
    case (pat)
      2'd0: begin
        if (!y[0] && !x[0])     pix_p0 = bar_rgb(bar_p0)[0] ? 8'hFF : 8'h00;
        else if (y[0] && x[0])  pix_p0 = bar_rgb(bar_p0)[2] ? 8'hFF : 8'h00;
        else                    pix_p0 = bar_rgb(bar_p0)[1] ? 8'hFF : 8'h00;
      end
      2'd1:    pix_p0 = 8'(x);
      2'd2:    pix_p0 = 8'(x) + 8'(y) + f;
      default: pix_p0 = 8'h80;
    endcase
  end

  // State, counters, frame counter and per-frame pattern capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      x     <= '0;
      y     <= '0;
      f     <= '0;
      pat   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        x <= '0;
        y <= '0;
      end else if (state != S_IDLE) begin
        if (line_end) begin
          x <= '0;
          y <= y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end
      if (state_nxt == S_VSYNC && state != S_VSYNC) pat <= pattern_sel;
      if (frame_end) f <= f + 8'd1;
    end
  end

  // ---- stage p0 -> output registers ----
  // Registered DVP outputs, one clock behind the state they describe
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_data       <= '0;
      out_vsync      <= 1'b0;
      out_hsync      <= 1'b0;
      out_frame_done <= 1'b0;
    end else begin
      out_data       <= href_p0 ? VIDEO_DATA_WIDTH'(pix_p0) : '0;
      out_vsync      <= (state == S_VSYNC);
      out_hsync      <= href_p0;
      out_frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_dvp_bayer_tx.sv
// Directed bench for dvp_bayer_tx with small frame geometry (LP = 20, frame = 160 clocks).
module tb_dvp_bayer_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic [7:0] out_data;
  logic       out_vsync;
  logic       out_hsync;
  logic       out_frame_done;

  dvp_bayer_tx #(
    .VIDEO_WIDTH(16), .VIDEO_HEIGHT(4), .VIDEO_DATA_WIDTH(8), .H_BLANK(4),
    .VSYNC_LINES(2), .V_BACK(1), .V_FRONT(1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
    .out_data(out_data), .out_vsync(out_vsync), .out_hsync(out_hsync),
    .out_frame_done(out_frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         scn;
    int         frame;
    int         line;
    int         col;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] cap [0:3][0:15];
  int         tests = 0;
  int         failed = 0;

  logic [7:0] bar_l0 [0:15] = '{8'hFF,8'hFF,8'h00,8'hFF,8'hFF,8'hFF,8'h00,8'hFF,
                                8'hFF,8'h00,8'h00,8'h00,8'hFF,8'h00,8'h00,8'h00};
  logic [7:0] bar_l1 [0:15] = '{8'hFF,8'hFF,8'hFF,8'hFF,8'hFF,8'h00,8'hFF,8'h00,
                                8'h00,8'hFF,8'h00,8'hFF,8'h00,8'h00,8'h00,8'h00};

  logic vs_t [0:330];
  logic hs_t [0:330];
  logic fd_t [0:330];
  logic [7:0] dt_t [0:330];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input int scn, input int fr, input int ln, input int col,
                              input logic [7:0] exp);
    vec_t v;
    v.scn = scn; v.frame = fr; v.line = ln; v.col = col; v.exp = exp;
    vecs.push_back(v);
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    enable = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic capture_frame();
    int guard;
    int line;
    int col;
    guard = 0;
    while (out_vsync !== 1'b1 && guard < 400) begin tick(); guard++; end
    check("vsync_seen", int'(out_vsync), 1);
    line = 0; col = 0; guard = 0;
    while (out_frame_done !== 1'b1 && guard < 400) begin
      tick(); guard++;
      if (out_hsync === 1'b1) begin
        if (line < 4) cap[line][col] = out_data;
        col++;
        if (col == 16) begin col = 0; line++; end
      end
    end
    check("frame_done_seen", int'(out_frame_done), 1);
    check("frame_pixels", line * 16 + col, 64);
  endtask

  task automatic check_vecs(input int scn, input int fr);
    foreach (vecs[i]) begin
      if (vecs[i].scn == scn && vecs[i].frame == fr)
        check($sformatf("pix s%0d f%0d l%0d x%0d", scn, fr, vecs[i].line, vecs[i].col),
              int'(cap[vecs[i].line][vecs[i].col]), int'(vecs[i].exp));
    end
  endtask

  initial begin
    int guard, nrise, hcount, cnt, vs_rise, vs_fall, hs_first, nb, nfd, bad;
    int bstart [0:7];
    int blen [0:7];
    int fdk [0:3];
    logic prev;

    // vector table: scenario 0 bars, 1 ramp, 2 diagonal, 3 pattern change
    for (int l = 0; l < 4; l++)
      for (int c = 0; c < 16; c++) begin
        add(0, 0, l, c, (l % 2 == 0) ? bar_l0[c] : bar_l1[c]);
        add(1, 0, l, c, 8'(c));
      end
    add(2, 0, 0, 0, 8'h00);   add(2, 0, 1, 3, 8'h04);
    add(2, 3, 2, 5, 8'h0A);   add(2, 3, 0, 0, 8'h03);   add(2, 3, 3, 15, 8'h15);
    add(2, 255, 0, 0, 8'hFF); add(2, 255, 1, 0, 8'h00);
    add(2, 256, 0, 0, 8'h00); add(2, 256, 2, 5, 8'h07);
    add(3, 0, 0, 3, 8'h80);   add(3, 0, 3, 15, 8'h80);
    add(3, 1, 1, 7, 8'h07);   add(3, 1, 2, 0, 8'h00);

    // reset state, with enable high during reset
    rst = 1'b0; enable = 1'b1; pattern_sel = 2'd2;
    repeat (3) tick();
    check("rst_data", int'(out_data), 0);
    check("rst_vsync", int'(out_vsync), 0);
    check("rst_hsync", int'(out_hsync), 0);
    check("rst_frame_done", int'(out_frame_done), 0);
    enable = 1'b0; rst = 1'b1;
    cnt = 0;
    repeat (10) begin tick(); if (out_vsync || out_hsync) cnt++; end
    check("idle_without_enable", cnt, 0);

    // timing trace, pattern 3
    do_reset();
    pattern_sel = 2'd3; enable = 1'b1;
    vs_t[0] = 0; hs_t[0] = 0; fd_t[0] = 0; dt_t[0] = 0;
    for (int k = 1; k <= 330; k++) begin
      tick();
      vs_t[k] = out_vsync; hs_t[k] = out_hsync; fd_t[k] = out_frame_done; dt_t[k] = out_data;
    end
    vs_rise = -1; vs_fall = -1; hs_first = -1; cnt = 0;
    for (int k = 1; k <= 161; k++) begin
      if (vs_t[k]) cnt++;
      if (vs_t[k] && !vs_t[k-1] && vs_rise < 0) vs_rise = k;
      if (!vs_t[k] && vs_t[k-1] && vs_fall < 0) vs_fall = k;
      if (hs_t[k] && hs_first < 0) hs_first = k;
    end
    check("vsync_first_rise", vs_rise, 2);
    check("vsync_high_cycles", cnt, 40);
    check("vsync_contiguous", vs_fall - vs_rise, 40);
    check("href_after_vsync", hs_first - vs_fall, 20);
    nb = 0;
    for (int k = 1; k <= 161; k++) begin
      if (hs_t[k] && !hs_t[k-1] && nb < 8) begin bstart[nb] = k; blen[nb] = 0; nb++; end
      if (hs_t[k] && nb > 0) blen[nb-1]++;
    end
    check("href_bursts", nb, 4);
    for (int b = 0; b < 4 && b < nb; b++) begin
      check($sformatf("href_len%0d", b), blen[b], 16);
      if (b > 0) check($sformatf("href_gap%0d", b), bstart[b] - bstart[b-1], 20);
    end
    bad = 0; nfd = 0;
    for (int k = 1; k <= 330; k++) begin
      if (hs_t[k] && dt_t[k] != 8'h80) bad++;
      if (!hs_t[k] && dt_t[k] != 8'h00) bad++;
      if (fd_t[k] && nfd < 4) begin fdk[nfd] = k; nfd++; end
    end
    check("grey_data_and_blank_zero", bad, 0);
    check("frame_done_pulses", nfd, 2);
    if (nfd >= 2) check("frame_done_period", fdk[1] - fdk[0], 160);

    // colour bars
    do_reset();
    pattern_sel = 2'd0; enable = 1'b1;
    capture_frame();
    check_vecs(0, 0);

    // ramp
    do_reset();
    pattern_sel = 2'd1; enable = 1'b1;
    capture_frame();
    check_vecs(1, 0);

    // moving diagonal over 257 frames, including frame-counter wrap
    do_reset();
    pattern_sel = 2'd2; enable = 1'b1;
    for (int fr = 0; fr <= 256; fr++) begin
      capture_frame();
      check_vecs(2, fr);
    end

    // enable dropped at start of active line 1
    do_reset();
    pattern_sel = 2'd3; enable = 1'b1;
    nrise = 0; prev = 1'b0; guard = 0;
    while (nrise < 2 && guard < 300) begin
      tick(); guard++;
      if (out_hsync && !prev) nrise++;
      prev = out_hsync;
    end
    check("drop_reach_line1", nrise, 2);
    enable = 1'b0;
    hcount = 0; guard = 0;
    while (out_frame_done !== 1'b1 && guard < 300) begin
      tick(); guard++;
      if (out_hsync) hcount++;
    end
    check("drop_frame_done", int'(out_frame_done), 1);
    check("drop_remaining_href", hcount, 47);
    cnt = 0;
    repeat (50) begin
      tick();
      if (out_vsync || out_hsync || out_frame_done || out_data != 8'h00) cnt++;
    end
    check("drop_idle_quiet", cnt, 0);

    // reset during an HREF burst
    do_reset();
    pattern_sel = 2'd3; enable = 1'b1;
    guard = 0;
    while (out_hsync !== 1'b1 && guard < 300) begin tick(); guard++; end
    check("rst_reach_href", int'(out_hsync), 1);
    rst = 1'b0;
    tick();
    check("abort_hsync", int'(out_hsync), 0);
    check("abort_vsync", int'(out_vsync), 0);
    check("abort_data", int'(out_data), 0);
    cnt = int'(out_frame_done);
    repeat (2) begin tick(); if (out_frame_done) cnt++; end
    check("abort_no_frame_done", cnt, 0);
    rst = 1'b1;
    tick();
    check("restart_vsync_edge1", int'(out_vsync), 0);
    tick();
    check("restart_vsync_edge2", int'(out_vsync), 1);

    // pattern change mid-frame
    do_reset();
    pattern_sel = 2'd3; enable = 1'b1;
    guard = 0;
    while (out_vsync !== 1'b1 && guard < 50) begin tick(); guard++; end
    check("patchg_vsync", int'(out_vsync), 1);
    pattern_sel = 2'd1;
    capture_frame();
    check_vecs(3, 0);
    capture_frame();
    check_vecs(3, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
